ibex_id_scoreboard: RTL and testbench
=====================================

IBEX_ID_SCOREBOARD -- requirements
Module: ibex_id_scoreboard

Interface
REQ-001 SHALL have parameter NREGS, default 32, meaning number of architectural registers; legal values 16 (RV32E) and 32.
REQ-002 SHALL have parameter LSU_DEPTH, default 2, meaning maximum outstanding loads; legal range 1..4.
REQ-003 SHALL have port clk_i  input  1  meaning the single clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port id_valid_i  input  1  meaning an instruction is present in ID.
REQ-006 SHALL have ports id_raddr_a_i / id_raddr_b_i  input  5 each  meaning source register addresses.
REQ-007 SHALL have ports id_re_a_i / id_re_b_i  input  1 each  meaning the matching source is read.
REQ-008 SHALL have port id_waddr_i  input  5  meaning destination register address.
REQ-009 SHALL have port id_we_i  input  1  meaning the instruction writes id_waddr_i.
REQ-010 SHALL have port id_is_load_i  input  1  meaning the instruction is a load whose result returns from the LSU.
REQ-011 SHALL have port ex_ready_i  input  1  meaning EX accepts an instruction this cycle.
REQ-012 SHALL have port flush_i  input  1  meaning the controller squashes the ID instruction this cycle.
REQ-013 SHALL have port lsu_valid_i  input  1  meaning the oldest outstanding load completes (data or error) this cycle.
REQ-014 SHALL have port stall_o  output  1  meaning ID is blocked by a hazard or a full load queue.
REQ-015 SHALL have port id_issue_o  output  1  meaning the ID instruction moves to EX this cycle.
REQ-016 SHALL have port pending_o  output  NREGS  meaning per-register outstanding-load bit.
REQ-017 SHALL have port lsu_cnt_o  output  3  meaning the number of outstanding loads.
REQ-018 SHALL have port lsu_full_o  output  1  meaning lsu_cnt_o equals LSU_DEPTH.
REQ-019 SHALL have port underflow_o  output  1  meaning a sticky flag set by lsu_valid_i with no load outstanding.

Function
REQ-020 SHALL compute hazard = (id_re_a_i & pend(id_raddr_a_i)) | (id_re_b_i & pend(id_raddr_b_i)) | (id_we_i & pend(id_waddr_i)).
REQ-021 SHALL define pend(x) = 0 when x == 0 or x >= NREGS, otherwise pending_o[x].
REQ-022 SHALL compute stall_o = id_valid_i & (hazard | (id_is_load_i & id_we_i & lsu_full_o & ~lsu_valid_i)), combinationally from inputs and state.
REQ-023 SHALL compute id_issue_o = id_valid_i & ~stall_o & ex_ready_i & ~flush_i.
REQ-024 SHALL, on a load issue (id_issue_o & id_is_load_i & id_we_i, id_waddr_i != 0 and < NREGS), push id_waddr_i into a LSU_DEPTH-entry FIFO and set pending_o[id_waddr_i] next cycle.
REQ-025 SHALL treat a load issue with id_waddr_i == 0 or >= NREGS as a no-op: no FIFO entry and no pending bit.
REQ-026 SHALL, on lsu_valid_i with lsu_cnt_o > 0, pop the FIFO head and clear pending_o[head] next cycle; load error completions behave identically.
REQ-027 SHALL provide no same-cycle bypass: a register whose load completes in cycle N still stalls a dependent instruction in cycle N and releases it in N+1.
REQ-028 SHALL allow push and pop in the same cycle when full, leaving lsu_cnt_o unchanged; when set and clear hit different registers, both SHALL take effect.
REQ-029 SHALL guarantee at most one FIFO entry per register, since WAW hazards stall (REQ-020).
REQ-030 SHALL, on lsu_valid_i with lsu_cnt_o == 0, leave all state unchanged except setting underflow_o, which holds until reset.
REQ-031 SHALL keep flush_i from affecting the FIFO or pending bits; in-flight loads always complete.
REQ-032 SHALL implement FIFO read/write pointers wrapping modulo LSU_DEPTH, with lsu_cnt_o as the authoritative occupancy.

Reset
REQ-033 SHALL, while rst_ni is low, asynchronously force pending_o = 0, lsu_cnt_o = 0, lsu_full_o = 0, underflow_o = 0 and FIFO pointers = 0.
REQ-034 SHALL discard outstanding loads on reset mid-operation; a later lsu_valid_i with an empty FIFO sets underflow_o.

Verification
REQ-035 SHALL test this sequence: issue load to x5, then next cycle id_re_a_i=1, id_raddr_a_i=5 -> stall_o=1 and pending_o[5]=1; lsu_valid_i=1 -> stall_o stays 1 that cycle and is 0 the next cycle.
REQ-036 SHALL test this sequence: LSU_DEPTH=2, loads to x3, x4 -> lsu_full_o=1; a third load to x6 -> stall_o=1; the same cycle with lsu_valid_i=1 -> the x6 load issues, lsu_cnt_o stays 2, pending_o[3] clears and pending_o[6] sets.
REQ-037 SHALL test this sequence: load to x0, or to x20 with NREGS=16 -> lsu_cnt_o stays 0 and pending_o stays 0; a read of x0 never stalls.
REQ-038 SHALL test this sequence: load to x7 pending, then a non-load with id_we_i=1 and id_waddr_i=7 -> stall_o=1 until one cycle after completion.
REQ-039 SHALL test this sequence: lsu_valid_i=1 with an empty FIFO -> underflow_o=1 and remains 1; then rst_ni=0 asynchronously mid-cycle -> underflow_o=0 and all pending bits=0 immediately.
REQ-040 SHALL test this sequence: flush_i=1 with a non-stalled load -> id_issue_o=0 and no FIFO change.

Source files
------------

// File: rtl/ibex_id_scoreboard_if.sv
// ID-stage issue handshake and LSU completion signals seen by the load scoreboard.
// Signal names keep the scoreboard-side _i/_o suffixes for drop-in compatibility.
interface ibex_id_scoreboard_if;
    logic       id_valid_i;
    logic [4:0] id_raddr_a_i;
    logic [4:0] id_raddr_b_i;
    logic       id_re_a_i;
    logic       id_re_b_i;
    logic [4:0] id_waddr_i;
    logic       id_we_i;
    logic       id_is_load_i;
    logic       ex_ready_i;
    logic       flush_i;
    logic       lsu_valid_i;
    logic       stall_o;
    logic       id_issue_o;

    modport slave (
        input  id_valid_i, id_raddr_a_i, id_raddr_b_i, id_re_a_i, id_re_b_i,
               id_waddr_i, id_we_i, id_is_load_i, ex_ready_i, flush_i, lsu_valid_i,
        output stall_o, id_issue_o
    );

    modport master (
        output id_valid_i, id_raddr_a_i, id_raddr_b_i, id_re_a_i, id_re_b_i,
               id_waddr_i, id_we_i, id_is_load_i, ex_ready_i, flush_i, lsu_valid_i,
        input  stall_o, id_issue_o
    );
endinterface

// File: rtl/ibex_id_scoreboard.sv
// Load-use scoreboard: tracks destination registers of outstanding loads in an
// in-order FIFO and stalls ID on RAW/WAW hazards or a full load queue.
module ibex_id_scoreboard #(
    parameter int unsigned NREGS     = 32,
    parameter int unsigned LSU_DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    ibex_id_scoreboard_if.slave  id_if,
    output logic [NREGS-1:0]     pending_o,
    output logic [2:0]           lsu_cnt_o,
    output logic                 lsu_full_o,
    output logic                 underflow_o
);
    localparam int unsigned     PW       = (LSU_DEPTH > 1) ? $clog2(LSU_DEPTH) : 1;
    localparam logic [PW-1:0]   PTR_LAST = PW'(LSU_DEPTH - 1);
    localparam logic [5:0]      NREGS_W  = 6'(NREGS);

    logic [4:0]       fifo_q [LSU_DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [NREGS-1:0] pending_q, pending_d;
    logic             underflow_q, underflow_d;
    logic [31:0]      pend_ext, pend_ext_d;
    logic             hazard, full, stall, issue, waddr_ok, push, pop;

    // 32-bit view of the pending bits: x0 and addresses >= NREGS read as clear
    always_comb begin
        pend_ext              = '0;
        pend_ext[NREGS-1:1]   = pending_q[NREGS-1:1];
    end

    assign full   = (cnt_q == 3'(LSU_DEPTH));
    assign hazard = (id_if.id_re_a_i & pend_ext[id_if.id_raddr_a_i]) |
                    (id_if.id_re_b_i & pend_ext[id_if.id_raddr_b_i]) |
                    (id_if.id_we_i   & pend_ext[id_if.id_waddr_i]);
    assign stall  = id_if.id_valid_i &
                    (hazard | (id_if.id_is_load_i & id_if.id_we_i & full & ~id_if.lsu_valid_i));
    assign issue  = id_if.id_valid_i & ~stall & id_if.ex_ready_i & ~id_if.flush_i;

    assign waddr_ok = (id_if.id_waddr_i != 5'd0) && ({1'b0, id_if.id_waddr_i} < NREGS_W);
    assign push     = issue & id_if.id_is_load_i & id_if.id_we_i & waddr_ok;
    assign pop      = id_if.lsu_valid_i & (cnt_q != 3'd0);

    always_comb begin
        pend_ext_d = pend_ext;
        // clear before set: a same-cycle set always targets a different register
        if (pop)  pend_ext_d[fifo_q[rptr_q]] = 1'b0;
        if (push) pend_ext_d[id_if.id_waddr_i] = 1'b1;
        pending_d = pend_ext_d[NREGS-1:0];

        wptr_d = wptr_q;
        if (push) wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PW'(1);
        rptr_d = rptr_q;
        if (pop)  rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PW'(1);

        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase

        underflow_d = underflow_q | (id_if.lsu_valid_i & (cnt_q == 3'd0));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < LSU_DEPTH; i++) fifo_q[i] <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            pending_q   <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (push) fifo_q[wptr_q] <= id_if.id_waddr_i;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            underflow_q <= underflow_d;
        end
    end

    assign id_if.stall_o    = stall;
    assign id_if.id_issue_o = issue;
    assign pending_o        = pending_q;
    assign lsu_cnt_o        = cnt_q;
    assign lsu_full_o       = full;
    assign underflow_o      = underflow_q;
endmodule

// File: tb/tb_ibex_id_scoreboard.sv
// Bench for ibex_id_scoreboard: NREGS=32 and NREGS=16 instances share stimulus and
// are compared each cycle against a list-based model of outstanding loads.
module tb_ibex_id_scoreboard;
    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ibex_id_scoreboard_if if32();
    ibex_id_scoreboard_if if16();

    logic [31:0] pend32;
    logic [15:0] pend16;
    logic [2:0]  cnt32, cnt16;
    logic        full32, full16, uf32, uf16;

    ibex_id_scoreboard #(.NREGS(32), .LSU_DEPTH(DEPTH)) u_dut32 (
        .clk_i(clk), .rst_ni(rst_n), .id_if(if32.slave),
        .pending_o(pend32), .lsu_cnt_o(cnt32), .lsu_full_o(full32), .underflow_o(uf32)
    );
    ibex_id_scoreboard #(.NREGS(16), .LSU_DEPTH(DEPTH)) u_dut16 (
        .clk_i(clk), .rst_ni(rst_n), .id_if(if16.slave),
        .pending_o(pend16), .lsu_cnt_o(cnt16), .lsu_full_o(full16), .underflow_o(uf16)
    );

    logic       s_valid, s_rea, s_reb, s_we, s_ld, s_rdy, s_fl, s_lv;
    logic [4:0] s_ra, s_rb, s_wa;

    assign if32.id_valid_i = s_valid;   assign if16.id_valid_i = s_valid;
    assign if32.id_raddr_a_i = s_ra;    assign if16.id_raddr_a_i = s_ra;
    assign if32.id_raddr_b_i = s_rb;    assign if16.id_raddr_b_i = s_rb;
    assign if32.id_re_a_i = s_rea;      assign if16.id_re_a_i = s_rea;
    assign if32.id_re_b_i = s_reb;      assign if16.id_re_b_i = s_reb;
    assign if32.id_waddr_i = s_wa;      assign if16.id_waddr_i = s_wa;
    assign if32.id_we_i = s_we;         assign if16.id_we_i = s_we;
    assign if32.id_is_load_i = s_ld;    assign if16.id_is_load_i = s_ld;
    assign if32.ex_ready_i = s_rdy;     assign if16.ex_ready_i = s_rdy;
    assign if32.flush_i = s_fl;         assign if16.flush_i = s_fl;
    assign if32.lsu_valid_i = s_lv;     assign if16.lsu_valid_i = s_lv;

    logic        o_stall [2];
    logic        o_issue [2];
    logic        o_full  [2];
    logic        o_uf    [2];
    logic [31:0] o_pend  [2];
    logic [2:0]  o_cnt   [2];

    assign o_stall[0] = if32.stall_o;    assign o_stall[1] = if16.stall_o;
    assign o_issue[0] = if32.id_issue_o; assign o_issue[1] = if16.id_issue_o;
    assign o_full[0]  = full32;          assign o_full[1]  = full16;
    assign o_uf[0]    = uf32;            assign o_uf[1]    = uf16;
    assign o_pend[0]  = pend32;          assign o_pend[1]  = {16'b0, pend16};
    assign o_cnt[0]   = cnt32;           assign o_cnt[1]   = cnt16;

    // Reference: ordered list of outstanding load destinations per instance
    int unsigned mq   [2][DEPTH];
    int unsigned mcnt [2];
    bit          muf  [2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned nregs_of(input int k);
        return (k == 0) ? 32 : 16;
    endfunction

    function automatic bit m_pend(input int k, input logic [4:0] a);
        if (a == 5'd0 || 32'(a) >= nregs_of(k)) return 1'b0;
        for (int i = 0; i < int'(mcnt[k]); i++)
            if (mq[k][i] == 32'(a)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_pendvec(input int k);
        logic [31:0] v = '0;
        for (int a = 1; a < 32; a++) v[a] = m_pend(k, 5'(a));
        return v;
    endfunction

    function automatic bit m_stall(input int k);
        bit hz;
        hz = (s_rea && m_pend(k, s_ra)) || (s_reb && m_pend(k, s_rb)) || (s_we && m_pend(k, s_wa));
        return s_valid && (hz || (s_ld && s_we && mcnt[k] == DEPTH && !s_lv));
    endfunction

    function automatic bit m_issue(input int k);
        return s_valid && !m_stall(k) && s_rdy && !s_fl;
    endfunction

    task automatic m_update();
        for (int k = 0; k < 2; k++) begin
            bit iss;
            iss = m_issue(k);
            if (s_lv) begin
                if (mcnt[k] > 0) begin
                    for (int i = 0; i < int'(DEPTH) - 1; i++) mq[k][i] = mq[k][i + 1];
                    mcnt[k]--;
                end else begin
                    muf[k] = 1'b1;
                end
            end
            if (iss && s_ld && s_we && s_wa != 5'd0 && 32'(s_wa) < nregs_of(k)) begin
                if (mcnt[k] < DEPTH) begin
                    mq[k][mcnt[k]] = 32'(s_wa);
                    mcnt[k]++;
                end
            end
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0;
            muf[k]  = 1'b0;
        end
    endtask

    task automatic set_in(input logic v, input logic [4:0] ra, input logic rea,
                          input logic [4:0] rb, input logic reb, input logic [4:0] wa,
                          input logic we, input logic ld, input logic rdy,
                          input logic fl, input logic lv);
        s_valid = v; s_ra = ra; s_rea = rea; s_rb = rb; s_reb = reb;
        s_wa = wa; s_we = we; s_ld = ld; s_rdy = rdy; s_fl = fl; s_lv = lv;
    endtask

    task automatic idle(input logic lv);
        set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, lv);
    endtask

    task automatic load(input logic [4:0] wa, input logic fl, input logic lv);
        set_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, wa, 1'b1, 1'b1, 1'b1, fl, lv);
    endtask

    task automatic settle_check();
        #2;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("stall[%0d]", k), 32'(o_stall[k]), 32'(m_stall(k)));
            check_eq($sformatf("issue[%0d]", k), 32'(o_issue[k]), 32'(m_issue(k)));
            check_eq($sformatf("pending[%0d]", k), o_pend[k], m_pendvec(k));
            check_eq($sformatf("cnt[%0d]", k), 32'(o_cnt[k]), mcnt[k]);
            check_eq($sformatf("full[%0d]", k), 32'(o_full[k]), 32'(mcnt[k] == DEPTH));
            check_eq($sformatf("underflow[%0d]", k), 32'(o_uf[k]), 32'(muf[k]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) m_update();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        idle(1'b0);
        @(posedge clk);
        #1;
        settle_check();
        rst_n = 1'b1;
        tick();
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 9) < 8) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(8, 31));
    endfunction

    initial begin
        idle(1'b0);
        m_reset();
        do_reset();

        // load-use RAW stall released one cycle after completion
        load(5'd5, 1'b0, 1'b0); settle_check(); check_eq("raw_issue_ld5", 32'(o_issue[0]), 1); tick();
        set_in(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        settle_check();
        check_eq("raw_stall", 32'(o_stall[0]), 1);
        check_eq("raw_pend5", 32'(o_pend[0][5]), 1);
        tick();
        s_lv = 1'b1; settle_check(); check_eq("raw_stall_cmpl", 32'(o_stall[0]), 1); tick();
        s_lv = 1'b0; settle_check(); check_eq("raw_release", 32'(o_stall[0]), 0); tick();

        // full queue: third load stalls unless the head completes that cycle
        do_reset();
        load(5'd3, 1'b0, 1'b0); settle_check(); tick();
        load(5'd4, 1'b0, 1'b0); settle_check(); tick();
        load(5'd6, 1'b0, 1'b0); settle_check();
        check_eq("full_flag", 32'(o_full[0]), 1);
        check_eq("full_stall", 32'(o_stall[0]), 1);
        tick();
        load(5'd6, 1'b0, 1'b1); settle_check();
        check_eq("full_pp_issue", 32'(o_issue[0]), 1);
        tick();
        idle(1'b0); settle_check();
        check_eq("full_pp_cnt", 32'(o_cnt[0]), 2);
        check_eq("full_pp_pend", o_pend[0] & 32'h0000_0058, 32'h0000_0050);
        tick();

        // x0 and out-of-range destinations are never tracked
        do_reset();
        load(5'd0, 1'b0, 1'b0); settle_check(); check_eq("x0_issue", 32'(o_issue[0]), 1); tick();
        idle(1'b0); settle_check(); check_eq("x0_cnt", 32'(o_cnt[0]), 0); check_eq("x0_pend", o_pend[0], 0);
        load(5'd20, 1'b0, 1'b0); settle_check(); tick();
        idle(1'b0); settle_check();
        check_eq("x20_cnt16", 32'(o_cnt[1]), 0);
        check_eq("x20_pend16", o_pend[1], 0);
        check_eq("x20_pend32", o_pend[0], 32'h0010_0000);
        set_in(1'b1, 5'd20, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        settle_check();
        check_eq("rd20_stall32", 32'(o_stall[0]), 1);
        check_eq("rd20_stall16", 32'(o_stall[1]), 0);
        set_in(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        settle_check(); check_eq("rd_x0_nostall", 32'(o_stall[0]), 0);
        tick();

        // WAW stall on a pending destination
        do_reset();
        load(5'd7, 1'b0, 1'b0); settle_check(); tick();
        set_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        settle_check(); check_eq("waw_stall", 32'(o_stall[0]), 1); tick();
        s_lv = 1'b1; settle_check(); check_eq("waw_stall_cmpl", 32'(o_stall[0]), 1); tick();
        s_lv = 1'b0; settle_check();
        check_eq("waw_release", 32'(o_stall[0]), 0);
        check_eq("waw_issue", 32'(o_issue[0]), 1);
        tick();

        // underflow is sticky until an asynchronous reset
        do_reset();
        idle(1'b1); settle_check(); tick();
        idle(1'b0); settle_check(); check_eq("uf_set", 32'(o_uf[0]), 1); tick();
        settle_check(); check_eq("uf_hold", 32'(o_uf[0]), 1);
        load(5'd9, 1'b0, 1'b0); settle_check(); tick();
        idle(1'b0); settle_check(); check_eq("uf_pend9", 32'(o_pend[0][9]), 1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_uf", 32'(o_uf[0]), 0);
        check_eq("arst_pend", o_pend[0], 0);
        check_eq("arst_cnt", 32'(o_cnt[0]), 0);
        m_reset();
        settle_check();
        rst_n = 1'b1;
        tick();

        // flush squashes the issue and leaves the queue alone
        load(5'd11, 1'b1, 1'b0); settle_check();
        check_eq("flush_issue", 32'(o_issue[0]), 0);
        check_eq("flush_nostall", 32'(o_stall[0]), 0);
        tick();
        idle(1'b0); settle_check();
        check_eq("flush_cnt", 32'(o_cnt[0]), 0);
        check_eq("flush_pend", o_pend[0], 0);
        tick();

        // randomized traffic, with occasional reset while loads are in flight
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            set_in(1'($urandom_range(0, 9) < 8), rnd_addr(), 1'($urandom_range(0, 1)),
                   rnd_addr(), 1'($urandom_range(0, 1)), rnd_addr(), 1'($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) != 0),
                   1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) < 3));
            settle_check();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
